// File: rtl/store_merge_rmw.sv
// Store unit between the MEM stage and data RAM: turns byte/half/word/double
// stores into full-width RAM writes, by read-modify-write or with byte strobes.
module store_merge_rmw #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int USE_WSTRB = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_re,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_wready,
  output logic                done,
  output logic                misalign_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam bit RMW   = (USE_WSTRB == 0);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_DONE} state_e;

  function automatic logic [DATA_W-1:0] lanes_to_bits(input logic [BYTES-1:0] lanes);
    logic [DATA_W-1:0] bits;
    for (int i = 0; i < BYTES; i++) bits[8*i +: 8] = {8{lanes[i]}};
    return bits;
  endfunction

  // Request decode, evaluated on the live request inputs in IDLE.
  logic [BYTES-1:0]  req_lanes;
  logic [2:0]        size_m1;
  logic [OFF_W+2:0]  shamt;
  logic [BYTES-1:0]  req_strb;
  logic [DATA_W-1:0] req_shifted;
  logic              req_misalign;
  logic              req_full;

  always_comb begin
    case (req_op)
      2'b00:   begin req_lanes = BYTES'(1);  size_m1 = 3'b000; end
      2'b01:   begin req_lanes = BYTES'(3);  size_m1 = 3'b001; end
      2'b10:   begin req_lanes = BYTES'(15); size_m1 = 3'b011; end
      default: begin req_lanes = '1;         size_m1 = 3'b111; end
    endcase
    shamt        = {req_addr[OFF_W-1:0], 3'b000};
    req_strb     = req_lanes << req_addr[OFF_W-1:0];
    req_shifted  = (req_data & lanes_to_bits(req_lanes)) << shamt;
    req_misalign = (|(req_addr[2:0] & size_m1)) || (req_op == 2'b11 && DATA_W == 32);
    req_full     = &req_lanes;
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;   // store data already shifted into its lanes
  logic [BYTES-1:0]  lanes_q, lanes_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BYTES-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    sdata_d     = sdata_q;
    lanes_d     = lanes_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (req_misalign) begin
          err_d = 1'b1;
        end else begin
          mem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          sdata_d    = req_shifted;
          lanes_d    = req_strb;
          if (!RMW || req_full) begin
            state_d     = S_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_shifted;
            mem_wstrb_d = RMW ? '1 : req_strb;
          end else begin
            state_d  = S_RD;
            mem_re_d = 1'b1;
          end
        end
      end
      S_RD: state_d = S_RWAIT;
      S_RWAIT: if (mem_rvalid) begin
        state_d     = S_WR;
        mem_we_d    = 1'b1;
        mem_wdata_d = (mem_rdata & ~lanes_to_bits(lanes_q)) | sdata_q;
        mem_wstrb_d = '1;
      end
      S_WR: if (mem_wready) begin
        state_d     = S_DONE;
        mem_we_d    = 1'b0;
        mem_wstrb_d = '0;
        done_d      = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sdata_q     <= '0;
      lanes_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking only, so every flop updates from the same pre-edge values.
      state_q     <= state_d;
      sdata_q     <= sdata_d;
      lanes_q     <= lanes_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign mem_addr     = mem_addr_q;
  assign mem_re       = mem_re_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign done         = done_q;
  assign misalign_err = err_q;
endmodule

// File: tb/tb_store_merge_rmw.sv
// Bench for store_merge_rmw: a 32-bit read-modify-write instance with a
// write scoreboard, and a 64-bit strobe-mode instance.
module tb_store_merge_rmw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_mem_re, a_mem_rvalid, a_mem_we, a_mem_wready, a_done, a_err;
  logic [1:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_data, a_mem_addr, a_mem_rdata, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;

  logic        b_req_valid, b_req_ready, b_mem_re, b_mem_rvalid, b_mem_we, b_mem_wready, b_done, b_err;
  logic [1:0]  b_req_op;
  logic [31:0] b_req_addr, b_mem_addr;
  logic [63:0] b_req_data, b_mem_rdata, b_mem_wdata;
  logic [7:0]  b_mem_wstrb;

  store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .USE_WSTRB(0)) u_rmw (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_op(a_req_op), .req_addr(a_req_addr), .req_data(a_req_data),
    .mem_addr(a_mem_addr), .mem_re(a_mem_re), .mem_rdata(a_mem_rdata), .mem_rvalid(a_mem_rvalid),
    .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_wready(a_mem_wready),
    .done(a_done), .misalign_err(a_err));

  store_merge_rmw #(.DATA_W(64), .ADDR_W(32), .USE_WSTRB(1)) u_strb (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op(b_req_op), .req_addr(b_req_addr), .req_data(b_req_data),
    .mem_addr(b_mem_addr), .mem_re(b_mem_re), .mem_rdata(b_mem_rdata), .mem_rvalid(b_mem_rvalid),
    .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_wready(b_mem_wready),
    .done(b_done), .misalign_err(b_err));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Observations of the last run_a transaction.
  int r_lat, r_re, r_we, r_done, r_err, r_err_cyc, r_busy;
  bit r_held;

  // Drives one store into the RMW instance and plays the RAM: read data
  // rd_dly cycles after mem_re, wready held low for wr_stall write cycles.
  task automatic run_a(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] ram, input int rd_dly, input int wr_stall);
    int          rd_cnt = 0;
    bit          rd_pend = 0;
    int          ws = wr_stall;
    logic [31:0] h_addr = '0;
    logic [31:0] h_data = '0;
    wr_t         e;
    r_lat = 0; r_re = 0; r_we = 0; r_done = 0; r_err = 0; r_err_cyc = 0; r_busy = 0; r_held = 1;
    @(negedge clk);
    a_req_valid = 1; a_req_op = op; a_req_addr = addr; a_req_data = data;
    a_mem_wready = 1; a_mem_rvalid = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      a_req_valid = 0; a_req_op = 2'($urandom); a_req_addr = $urandom; a_req_data = $urandom;
      if (!a_req_ready) r_busy++;
      if (a_done) begin r_done++; if (r_lat == 0) r_lat = cyc + 1; end
      if (a_err) begin r_err++; r_err_cyc = cyc; end
      a_mem_rvalid = 0; a_mem_rdata = $urandom;
      if (a_mem_re) begin
        r_re++;
        checks++;
        if (a_mem_addr !== {addr[31:2], 2'b00}) begin
          errors++; $display("FAIL rd_addr: got %h want %h", a_mem_addr, {addr[31:2], 2'b00});
        end
        rd_pend = 1; rd_cnt = rd_dly;
        a_mem_rvalid = 1;  // stray rvalid during RD must be ignored
      end else if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin a_mem_rvalid = 1; a_mem_rdata = ram; rd_pend = 0; end
      end
      if (a_mem_we) begin
        r_we++;
        if (r_we == 1) begin h_addr = a_mem_addr; h_data = a_mem_wdata; end
        else if (a_mem_addr !== h_addr || a_mem_wdata !== h_data) r_held = 0;
        if (ws > 0) begin
          a_mem_wready = 0; ws--;
        end else begin
          a_mem_wready = 1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_write: addr=%h data=%h", a_mem_addr, a_mem_wdata);
          end else begin
            e = exp_q.pop_front();
            if ({a_mem_addr, a_mem_wdata, a_mem_wstrb} !== e) begin
              errors++;
              $display("FAIL write: got addr=%h data=%h strb=%b want addr=%h data=%h strb=%b",
                       a_mem_addr, a_mem_wdata, a_mem_wstrb, e.addr, e.data, e.strb);
            end
          end
        end
      end else begin
        a_mem_wready = 1;
      end
    end
  endtask

  task automatic run_b(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] data,
                       output logic [63:0] w_data, output logic [7:0] w_strb,
                       output int lat, output int n_re, output int n_err);
    w_data = '0; w_strb = '0; lat = 0; n_re = 0; n_err = 0;
    @(negedge clk);
    b_req_valid = 1; b_req_op = op; b_req_addr = addr; b_req_data = data; b_mem_wready = 1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      b_req_valid = 0; b_req_data = {$urandom, $urandom}; b_req_addr = $urandom;
      b_mem_rvalid = 1'($urandom); b_mem_rdata = {$urandom, $urandom};
      if (b_mem_re) n_re++;
      if (b_mem_we) begin w_data = b_mem_wdata; w_strb = b_mem_wstrb; end
      if (b_done && lat == 0) lat = cyc + 1;
      if (b_err) n_err++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_req_ready, a_mem_re, a_mem_we, a_done, a_err} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl_a: got %b want 10000", {a_req_ready, a_mem_re, a_mem_we, a_done, a_err});
    end
    checks++;
    if ({a_mem_addr, a_mem_wdata, a_mem_wstrb} !== '0) begin
      errors++; $display("FAIL reset_data_a: got addr=%h data=%h strb=%b want zeros", a_mem_addr, a_mem_wdata, a_mem_wstrb);
    end
    checks++;
    if ({b_req_ready, b_mem_re, b_mem_we, b_done, b_err, b_mem_addr, b_mem_wdata, b_mem_wstrb} !== {1'b1, 108'b0}) begin
      errors++; $display("FAIL reset_b: got ready=%b we=%b addr=%h data=%h strb=%h", b_req_ready, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_wstrb);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({a_req_ready, b_req_ready} !== 2'b11) begin
      errors++; $display("FAIL ready_after_reset: got %b want 11", {a_req_ready, b_req_ready});
    end
  endtask

  task automatic test_rmw_byte;
    exp_q.push_back('{addr: 32'h1000, data: 32'h1122AB44, strb: 4'hF});
    run_a(2'b00, 32'h1001, 32'h000000AB, 32'h11223344, 1, 0);
    checks++; if (r_re !== 1) begin errors++; $display("FAIL sb_re_count: got %0d want 1", r_re); end
    checks++; if (r_lat !== 5) begin errors++; $display("FAIL sb_latency: got %0d want 5", r_lat); end
    checks++; if (r_done !== 1) begin errors++; $display("FAIL sb_done_count: got %0d want 1", r_done); end
    checks++; if (r_busy !== 4) begin errors++; $display("FAIL sb_busy_cycles: got %0d want 4", r_busy); end
  endtask

  task automatic test_rmw_half;
    exp_q.push_back('{addr: 32'h2000, data: 32'hBEEF0000, strb: 4'hF});
    run_a(2'b01, 32'h2002, 32'h1234BEEF, 32'hCAFE0000, 1, 0);
    checks++; if (r_re !== 1) begin errors++; $display("FAIL sh_re_count: got %0d want 1", r_re); end
    checks++; if (r_lat !== 5) begin errors++; $display("FAIL sh_latency: got %0d want 5", r_lat); end
  endtask

  task automatic test_full_word;
    exp_q.push_back('{addr: 32'h3000, data: 32'hDEADBEEF, strb: 4'hF});
    run_a(2'b10, 32'h3000, 32'hDEADBEEF, 32'h55555555, 1, 0);
    checks++; if (r_re !== 0) begin errors++; $display("FAIL sw_re_count: got %0d want 0", r_re); end
    checks++; if (r_lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", r_lat); end
    checks++; if (r_busy !== 2) begin errors++; $display("FAIL sw_busy_cycles: got %0d want 2", r_busy); end
  endtask

  task automatic test_misalign;
    logic [1:0]  ops[2]   = '{2'b01, 2'b11};
    logic [31:0] addrs[2] = '{32'h1003, 32'h0};
    for (int i = 0; i < 2; i++) begin
      run_a(ops[i], addrs[i], 32'h12345678, 32'h0, 1, 0);
      checks++;
      if (r_err !== 1 || r_err_cyc !== 1) begin
        errors++; $display("FAIL misalign_pulse[%0d]: got count=%0d cycle=%0d want count=1 cycle=1", i, r_err, r_err_cyc);
      end
      checks++;
      if (r_re !== 0 || r_we !== 0 || r_done !== 0) begin
        errors++; $display("FAIL misalign_no_access[%0d]: got re=%0d we=%0d done=%0d want 0 0 0", i, r_re, r_we, r_done);
      end
    end
  endtask

  task automatic test_stall;
    exp_q.push_back('{addr: 32'h4000, data: 32'hA5A577A5, strb: 4'hF});
    run_a(2'b00, 32'h4001, 32'hFFFFFF77, 32'hA5A5A5A5, 4, 3);
    checks++; if (r_held !== 1'b1) begin errors++; $display("FAIL stall_held: addr/data changed while mem_we high"); end
    checks++; if (r_we !== 4) begin errors++; $display("FAIL stall_we_cycles: got %0d want 4", r_we); end
    checks++; if (r_done !== 1) begin errors++; $display("FAIL stall_done_count: got %0d want 1", r_done); end
    checks++; if (r_lat !== 11) begin errors++; $display("FAIL stall_latency: got %0d want 11", r_lat); end
  endtask

  task automatic test_reset_mid;
    int n_we = 0, n_re = 0, n_done = 0;
    @(negedge clk);
    a_req_valid = 1; a_req_op = 2'b00; a_req_addr = 32'h5002; a_req_data = 32'h99;
    a_mem_rvalid = 0; a_mem_wready = 1;
    @(negedge clk);
    a_req_valid = 0;
    checks++; if (a_mem_re !== 1'b1) begin errors++; $display("FAIL rst_mid_re: got %b want 1", a_mem_re); end
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({a_req_ready, a_mem_re, a_mem_we, a_done, a_err, a_mem_addr, a_mem_wdata, a_mem_wstrb} !== {1'b1, 72'b0}) begin
      errors++; $display("FAIL rst_mid_outputs: got ready=%b re=%b we=%b addr=%h data=%h strb=%b",
                         a_req_ready, a_mem_re, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_wstrb);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_mem_rvalid = (i < 3); a_mem_rdata = $urandom;
      if (a_mem_we) n_we++;
      if (a_mem_re) n_re++;
      if (a_done) n_done++;
    end
    a_mem_rvalid = 0;
    checks++;
    if (n_we !== 0 || n_re !== 0 || n_done !== 0) begin
      errors++; $display("FAIL rst_mid_no_write: got we=%0d re=%0d done=%0d want 0 0 0", n_we, n_re, n_done);
    end
  endtask

  task automatic test_strobe64;
    logic [1:0]  ops[4]   = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] addrs[4] = '{32'h07, 32'h12, 32'h0C, 32'h08};
    logic [63:0] datas[4] = '{64'h5A, 64'hFFFF_1234, 64'hCAFEF00D, 64'h0123_4567_89AB_CDEF};
    logic [63:0] exp_d[4] = '{64'h5A00_0000_0000_0000, 64'h0000_0000_1234_0000,
                              64'hCAFE_F00D_0000_0000, 64'h0123_4567_89AB_CDEF};
    logic [7:0]  exp_s[4] = '{8'h80, 8'h0C, 8'hF0, 8'hFF};
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    int          lat, n_re, n_err;
    for (int i = 0; i < 4; i++) begin
      run_b(ops[i], addrs[i], datas[i], w_data, w_strb, lat, n_re, n_err);
      checks++; if (w_data !== exp_d[i]) begin errors++; $display("FAIL strb_wdata[%0d]: got %h want %h", i, w_data, exp_d[i]); end
      checks++; if (w_strb !== exp_s[i]) begin errors++; $display("FAIL strb_wstrb[%0d]: got %h want %h", i, w_strb, exp_s[i]); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL strb_latency[%0d]: got %0d want 3", i, lat); end
      checks++; if (n_re !== 0) begin errors++; $display("FAIL strb_no_read[%0d]: got %0d want 0", i, n_re); end
    end
    run_b(2'b10, 32'h2, 64'h1, w_data, w_strb, lat, n_re, n_err);
    checks++;
    if (n_err !== 1 || w_strb !== 8'h00 || lat !== 0) begin
      errors++; $display("FAIL strb_misalign: got err=%0d strb=%h done_lat=%0d want 1 00 0", n_err, w_strb, lat);
    end
  endtask

  initial begin
    {a_req_valid, a_req_op, a_req_addr, a_req_data, a_mem_rdata, a_mem_rvalid, a_mem_wready} = '0;
    {b_req_valid, b_req_op, b_req_addr, b_req_data, b_mem_rdata, b_mem_rvalid, b_mem_wready} = '0;
    test_reset();
    test_rmw_byte();
    test_rmw_half();
    test_full_word();
    test_misalign();
    test_stall();
    test_reset_mid();
    test_strobe64();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected writes never seen", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
